opnd_collect: RTL and testbench
===============================

OPND_COLLECT -- requirements
Module: opnd_collect

Interface
REQ-001 Parameter DATA_W, default 32, operand/data width.
REQ-002 Parameter NFWD, default 3, number of forwarding channels; index 0 = youngest producer, highest priority.
REQ-003 Parameter RADDR_W, default 5, register address width.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 in_valid / in_ready  in / out  1 / 1  upstream handshake; transfer when both high.
REQ-007 ityp, func  in  `W_TYPE, `W_FUNC  instruction class and ALU function.
REQ-008 imme  in  DATA_W  extended immediate.
REQ-009 rs_addr, rt_addr  in  RADDR_W  source register numbers.
REQ-010 rs_data, rt_data  in  DATA_W  register-file read values.
REQ-011 fwd_valid, fwd_rdy  in  NFWD  channel holds a write to fwd_addr; data present only when fwd_rdy.
REQ-012 fwd_addr  in  NFWD x RADDR_W; fwd_data  in  NFWD x DATA_W.
REQ-013 flush  in  1  discard held instruction.
REQ-014 out_valid / out_ready  out / in  1 / 1  downstream handshake.
REQ-015 source_a, source_b  out  DATA_W  registered ALU operands.
REQ-016 stall_cycles  out  16  saturating count of WAIT cycles since reset.

Function
REQ-017 Operand mapping: TYPE_R with FUNC_SLL/SRL/SRA -> a=rt, b=rs; other TYPE_R -> a=rs, b=rt; TYPE_I with FUNC_ADD/FUNC_SLT -> a=rs, b=imme; other TYPE_I -> a=rt, b=imme; all other types -> a=rt, b=imme.
REQ-018 A register operand is resolved per channel search: lowest index i with fwd_valid[i] and fwd_addr[i]==addr wins; if that channel has fwd_rdy[i], take fwd_data[i]; else operand is pending; if no match, take register-file data.
REQ-019 Register 0 never matches any channel; always reads register-file data.
REQ-020 States: EMPTY, WAIT, FULL; in_ready high in EMPTY, or in FULL when out_ready.
REQ-021 On transfer: all operands resolved -> FULL with outputs loaded next edge; any pending -> WAIT, latching resolved operands and addresses of pending ones.
REQ-022 In WAIT each cycle re-searches channels for pending operands only; resolved operands latch individually; when none pending, FULL next edge; rs_data/rt_data are not re-sampled in WAIT.
REQ-023 In WAIT, a pending operand whose matching channel disappears (no match) takes the value captured from register file at transfer.
REQ-024 FULL with out_ready and no new transfer -> EMPTY; with simultaneous transfer -> back-to-back load (FULL or WAIT), no bubble.
REQ-025 out_valid high only in FULL; source_a/source_b stable while out_valid and not out_ready.
REQ-026 Latency: all-resolved instruction appears out_valid on the edge after transfer (1 cycle).
REQ-027 flush -> EMPTY next edge regardless of state; flush wins over simultaneous transfer; source registers unchanged.
REQ-028 stall_cycles increments every cycle in WAIT, saturates at 16'hFFFF.

Reset
REQ-029 On resetn low, immediately: state EMPTY, out_valid 0, source_a 0, source_b 0, stall_cycles 0, all latched addresses and pending flags 0.
REQ-030 Reset during WAIT or FULL discards the instruction; in_ready high the first edge after release.

Structure
REQ-031 TYPE_*/FUNC_* constants and W_* widths come from the shared defines; state enum belongs in a shared package (opnd_pkg).
REQ-032 One sub-module fwd_mux (priority search of REQ-018/019, outputs data, hit, pending), instantiated once per register operand.

Verification
REQ-033 ADD R-type, rs=3 rt=4, no forwards, rs_data=10, rt_data=20 -> one cycle later out_valid, a=10, b=20.
REQ-034 SLL R-type rs=2 rt=5, fwd0 {addr 5, data 7, rdy} and fwd1 {addr 5, data 9, rdy} -> a=7 (channel 0 priority), b=rs_data.
REQ-035 ADD I-type rs=8, fwd2 {addr 8, rdy=0} for 3 cycles then rdy with data 0x55 -> WAIT 3 cycles, a=0x55, b=imme, stall_cycles=3.
REQ-036 rs=0 with fwd0 {addr 0, data 0xFF, rdy} -> a=rs_data (0).
REQ-037 out_ready low 4 cycles with new in_valid -> in_ready low, operands stable; out_ready high plus in_valid -> next instruction loaded without bubble.
REQ-038 flush in WAIT, then resetn low in FULL -> EMPTY each time, out_valid 0, outputs 0 after reset.

Source files
------------

// File: rtl/opnd_pkg.sv
// Shared operand-collector definitions: instruction encodings, state enum and
// the instruction-class to operand-source mapping.
package opnd_pkg;

   localparam int unsigned W_TYPE  = 3;
   localparam int unsigned W_FUNC  = 4;
   localparam int unsigned STALL_W = 16;

   localparam logic [W_TYPE-1:0] TYPE_R = 3'd0;
   localparam logic [W_TYPE-1:0] TYPE_I = 3'd1;
   localparam logic [W_TYPE-1:0] TYPE_J = 3'd2;
   localparam logic [W_TYPE-1:0] TYPE_M = 3'd3;

   localparam logic [W_FUNC-1:0] FUNC_ADD = 4'd0;
   localparam logic [W_FUNC-1:0] FUNC_SUB = 4'd1;
   localparam logic [W_FUNC-1:0] FUNC_AND = 4'd2;
   localparam logic [W_FUNC-1:0] FUNC_OR  = 4'd3;
   localparam logic [W_FUNC-1:0] FUNC_XOR = 4'd4;
   localparam logic [W_FUNC-1:0] FUNC_SLT = 4'd5;
   localparam logic [W_FUNC-1:0] FUNC_SLL = 4'd6;
   localparam logic [W_FUNC-1:0] FUNC_SRL = 4'd7;
   localparam logic [W_FUNC-1:0] FUNC_SRA = 4'd8;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_WAIT  = 2'd1,
      ST_FULL  = 2'd2
   } opnd_state_e;

   typedef enum logic [1:0] {
      B_RS  = 2'd0,
      B_RT  = 2'd1,
      B_IMM = 2'd2
   } b_sel_e;

   typedef struct packed {
      logic   a_is_rt;
      b_sel_e b_sel;
   } opnd_map_t;

   // Shifts take the shifted value from rt; reg-imm ADD/SLT use rs as the base.
   function automatic opnd_map_t opnd_map(input logic [W_TYPE-1:0] ityp,
                                          input logic [W_FUNC-1:0] func);
      opnd_map_t m;
      m.a_is_rt = 1'b1;
      m.b_sel   = B_IMM;
      if (ityp == TYPE_R) begin
         if (func == FUNC_SLL || func == FUNC_SRL || func == FUNC_SRA) begin
            m.a_is_rt = 1'b1;
            m.b_sel   = B_RS;
         end else begin
            m.a_is_rt = 1'b0;
            m.b_sel   = B_RT;
         end
      end else if (ityp == TYPE_I && (func == FUNC_ADD || func == FUNC_SLT)) begin
         m.a_is_rt = 1'b0;
         m.b_sel   = B_IMM;
      end
      return m;
   endfunction

endpackage

// File: rtl/opnd_collect_fwd_mux.sv
// Priority search of the forwarding channels for one register operand.
// Channel 0 is the youngest producer; register 0 is never forwarded.
module fwd_mux #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned NFWD    = 3,
   parameter int unsigned RADDR_W = 5
) (
   input  logic [RADDR_W-1:0]            addr,
   input  logic [NFWD-1:0]               fwd_valid,
   input  logic [NFWD-1:0]               fwd_rdy,
   input  logic [NFWD-1:0][RADDR_W-1:0]  fwd_addr,
   input  logic [NFWD-1:0][DATA_W-1:0]   fwd_data,
   output logic [DATA_W-1:0]             data,
   output logic                          hit,
   output logic                          pending
);

   logic sel_rdy;

   // Walk from oldest to youngest so the lowest matching index is left standing.
   always_comb begin
      hit     = 1'b0;
      sel_rdy = 1'b0;
      data    = '0;
      for (int i = int'(NFWD) - 1; i >= 0; i--) begin
         if (fwd_valid[i] && fwd_addr[i] == addr && addr != '0) begin
            hit     = 1'b1;
            sel_rdy = fwd_rdy[i];
            data    = fwd_data[i];
         end
      end
      pending = hit && !sel_rdy;
   end

endmodule

// File: rtl/opnd_collect.sv
// Operand collector: captures an instruction, resolves its register operands
// through the forwarding network and presents registered ALU sources.
module opnd_collect
   import opnd_pkg::*;
#(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned NFWD    = 3,
   parameter int unsigned RADDR_W = 5
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [W_TYPE-1:0]             ityp,
   input  logic [W_FUNC-1:0]             func,
   input  logic [DATA_W-1:0]             imme,
   input  logic [RADDR_W-1:0]            rs_addr,
   input  logic [RADDR_W-1:0]            rt_addr,
   input  logic [DATA_W-1:0]             rs_data,
   input  logic [DATA_W-1:0]             rt_data,
   input  logic [NFWD-1:0]               fwd_valid,
   input  logic [NFWD-1:0]               fwd_rdy,
   input  logic [NFWD-1:0][RADDR_W-1:0]  fwd_addr,
   input  logic [NFWD-1:0][DATA_W-1:0]   fwd_data,
   input  logic                          flush,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_W-1:0]             source_a,
   output logic [DATA_W-1:0]             source_b,
   output logic [STALL_W-1:0]            stall_cycles
);

   opnd_state_e state, state_n;
   logic        capture, load_src;

   opnd_map_t          map;
   logic               b_is_reg, in_wait;
   logic [RADDR_W-1:0] new_a_addr, new_b_addr, a_addr_q, b_addr_q;
   logic [RADDR_W-1:0] mux_a_addr, mux_b_addr;
   logic [DATA_W-1:0]  new_a_rf, new_b_rf, a_hold, b_hold, mux_a_rf, mux_b_rf;
   logic [DATA_W-1:0]  fa_data, fb_data, res_a, res_b, a_val, b_val;
   logic               fa_hit, fa_pend, fb_hit, fb_pend;
   logic               a_pend_q, b_pend_q, a_pnd, b_pnd;

   assign map        = opnd_map(ityp, func);
   assign b_is_reg   = (map.b_sel != B_IMM);
   assign new_a_addr = map.a_is_rt ? rt_addr : rs_addr;
   assign new_a_rf   = map.a_is_rt ? rt_data : rs_data;
   assign new_b_addr = (map.b_sel == B_RS) ? rs_addr : rt_addr;
   assign new_b_rf   = (map.b_sel == B_RS) ? rs_data : rt_data;

   // While waiting, search with the latched address and fall back to the
   // register-file value captured at transfer time.
   assign in_wait    = (state == ST_WAIT);
   assign mux_a_addr = in_wait ? a_addr_q : new_a_addr;
   assign mux_b_addr = in_wait ? b_addr_q : new_b_addr;
   assign mux_a_rf   = in_wait ? a_hold   : new_a_rf;
   assign mux_b_rf   = in_wait ? b_hold   : new_b_rf;

   fwd_mux #(.DATA_W(DATA_W), .NFWD(NFWD), .RADDR_W(RADDR_W)) u_mux_a (
      .addr(mux_a_addr), .fwd_valid(fwd_valid), .fwd_rdy(fwd_rdy),
      .fwd_addr(fwd_addr), .fwd_data(fwd_data),
      .data(fa_data), .hit(fa_hit), .pending(fa_pend)
   );

   fwd_mux #(.DATA_W(DATA_W), .NFWD(NFWD), .RADDR_W(RADDR_W)) u_mux_b (
      .addr(mux_b_addr), .fwd_valid(fwd_valid), .fwd_rdy(fwd_rdy),
      .fwd_addr(fwd_addr), .fwd_data(fwd_data),
      .data(fb_data), .hit(fb_hit), .pending(fb_pend)
   );

   assign res_a = (fa_hit && !fa_pend) ? fa_data : mux_a_rf;
   assign res_b = (fb_hit && !fb_pend) ? fb_data : mux_b_rf;

   assign a_val = (in_wait && !a_pend_q) ? a_hold : res_a;
   assign a_pnd = in_wait ? (a_pend_q && fa_pend) : fa_pend;
   assign b_val = in_wait ? (b_pend_q ? res_b : b_hold)
                          : (b_is_reg ? res_b : imme);
   assign b_pnd = in_wait ? (b_pend_q && fb_pend) : (b_is_reg && fb_pend);

   assign in_ready  = (state == ST_EMPTY) || (state == ST_FULL && out_ready);
   assign out_valid = (state == ST_FULL);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= ST_EMPTY;
      else         state <= state_n;
   end

   // Next state plus load strobes; flush overrides any concurrent transfer.
   always_comb begin
      state_n  = state;
      capture  = 1'b0;
      load_src = 1'b0;
      if (flush) begin
         state_n = ST_EMPTY;
      end else begin
         case (state)
            ST_EMPTY, ST_FULL: begin
               if (in_valid && in_ready) begin
                  if (a_pnd || b_pnd) begin
                     state_n = ST_WAIT;
                     capture = 1'b1;
                  end else begin
                     state_n  = ST_FULL;
                     load_src = 1'b1;
                  end
               end else if (state == ST_FULL && out_ready) begin
                  state_n = ST_EMPTY;
               end
            end
            ST_WAIT: begin
               capture = 1'b1;
               if (!a_pnd && !b_pnd) begin
                  state_n  = ST_FULL;
                  load_src = 1'b1;
               end
            end
            default: state_n = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         a_hold       <= '0;
         b_hold       <= '0;
         a_pend_q     <= 1'b0;
         b_pend_q     <= 1'b0;
         a_addr_q     <= '0;
         b_addr_q     <= '0;
         source_a     <= '0;
         source_b     <= '0;
         stall_cycles <= '0;
      end else begin
         if (capture) begin
            a_hold   <= a_val;
            b_hold   <= b_val;
            a_pend_q <= a_pnd;
            b_pend_q <= b_pnd;
            a_addr_q <= mux_a_addr;
            b_addr_q <= mux_b_addr;
         end
         if (load_src) begin
            source_a <= a_val;
            source_b <= b_val;
         end
         if (in_wait && stall_cycles != '1)
            stall_cycles <= stall_cycles + STALL_W'(1);
      end
   end

endmodule

// File: tb/tb_opnd_collect.sv
// Self-checking bench for opnd_collect: directed scenarios plus a randomized
// run compared against a transaction-level reference model.
module tb_opnd_collect;
   import opnd_pkg::*;

   localparam int DATA_W  = 32;
   localparam int NFWD    = 3;
   localparam int RADDR_W = 5;

   logic                          clk = 1'b0;
   logic                          resetn;
   logic                          in_valid, in_ready;
   logic [W_TYPE-1:0]             ityp;
   logic [W_FUNC-1:0]             func;
   logic [DATA_W-1:0]             imme, rs_data, rt_data;
   logic [RADDR_W-1:0]            rs_addr, rt_addr;
   logic [NFWD-1:0]               fwd_valid, fwd_rdy;
   logic [NFWD-1:0][RADDR_W-1:0]  fwd_addr;
   logic [NFWD-1:0][DATA_W-1:0]   fwd_data;
   logic                          flush, out_valid, out_ready;
   logic [DATA_W-1:0]             source_a, source_b;
   logic [15:0]                   stall_cycles;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: 0 = empty, 1 = waiting on forwards, 2 = holding result
   int               m_st;
   bit               m_pend [2];
   logic [DATA_W-1:0] m_val [2];
   logic [RADDR_W-1:0] m_addr [2];
   logic [DATA_W-1:0] m_src [2];
   int               m_stall;

   opnd_collect #(.DATA_W(DATA_W), .NFWD(NFWD), .RADDR_W(RADDR_W)) dut (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
      .ityp(ityp), .func(func), .imme(imme), .rs_addr(rs_addr),
      .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
      .fwd_valid(fwd_valid), .fwd_rdy(fwd_rdy), .fwd_addr(fwd_addr),
      .fwd_data(fwd_data), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .source_a(source_a), .source_b(source_b),
      .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   function automatic void decode(input logic [W_TYPE-1:0] t, input logic [W_FUNC-1:0] f,
                                  output bit a_rt, output int b_kind);
      if (t == TYPE_R) begin
         if (f == FUNC_SLL || f == FUNC_SRL || f == FUNC_SRA) begin a_rt = 1; b_kind = 0; end
         else begin a_rt = 0; b_kind = 1; end
      end else if (t == TYPE_I && (f == FUNC_ADD || f == FUNC_SLT)) begin
         a_rt = 0; b_kind = 2;
      end else begin
         a_rt = 1; b_kind = 2;
      end
   endfunction

   function automatic void resolve(input logic [RADDR_W-1:0] addr, input logic [DATA_W-1:0] rf,
                                   output bit pend, output logic [DATA_W-1:0] val);
      bit found = 0;
      pend = 0;
      val  = rf;
      if (addr != 0) begin
         for (int i = 0; i < NFWD; i++) begin
            if (!found && fwd_valid[i] && fwd_addr[i] == addr) begin
               found = 1;
               if (fwd_rdy[i]) val = fwd_data[i];
               else pend = 1;
            end
         end
      end
   endfunction

   function automatic bit model_in_ready();
      return (m_st == 0) || (m_st == 2 && out_ready);
   endfunction

   task automatic model_clear();
      m_st = 0; m_stall = 0;
      for (int k = 0; k < 2; k++) begin
         m_pend[k] = 0; m_val[k] = '0; m_addr[k] = '0; m_src[k] = '0;
      end
   endtask

   // Advance one clock, updating the model from the inputs present before the edge.
   task automatic tick();
      int n_st = m_st;
      int n_stall = m_stall;
      bit n_pend [2];
      logic [DATA_W-1:0] n_val [2];
      logic [RADDR_W-1:0] n_addr [2];
      logic [DATA_W-1:0] n_src [2];
      bit a_rt, p;
      int b_kind;
      logic [DATA_W-1:0] v;
      for (int k = 0; k < 2; k++) begin
         n_pend[k] = m_pend[k]; n_val[k] = m_val[k]; n_addr[k] = m_addr[k]; n_src[k] = m_src[k];
      end
      if (m_st == 1 && m_stall < 65535) n_stall = m_stall + 1;
      if (flush) begin
         n_st = 0;
      end else if (m_st == 1) begin
         for (int k = 0; k < 2; k++) begin
            if (m_pend[k]) begin
               resolve(m_addr[k], m_val[k], p, v);
               n_pend[k] = p; n_val[k] = v;
            end
         end
         if (!n_pend[0] && !n_pend[1]) begin
            n_st = 2; n_src[0] = n_val[0]; n_src[1] = n_val[1];
         end
      end else if (in_valid && model_in_ready()) begin
         decode(ityp, func, a_rt, b_kind);
         n_addr[0] = a_rt ? rt_addr : rs_addr;
         resolve(n_addr[0], a_rt ? rt_data : rs_data, p, v);
         n_pend[0] = p; n_val[0] = v;
         if (b_kind == 2) begin
            n_pend[1] = 0; n_val[1] = imme;
         end else begin
            n_addr[1] = (b_kind == 0) ? rs_addr : rt_addr;
            resolve(n_addr[1], (b_kind == 0) ? rs_data : rt_data, p, v);
            n_pend[1] = p; n_val[1] = v;
         end
         if (n_pend[0] || n_pend[1]) n_st = 1;
         else begin n_st = 2; n_src[0] = n_val[0]; n_src[1] = n_val[1]; end
      end else if (m_st == 2 && out_ready) begin
         n_st = 0;
      end
      @(posedge clk);
      #1;
      m_st = n_st; m_stall = n_stall;
      for (int k = 0; k < 2; k++) begin
         m_pend[k] = n_pend[k]; m_val[k] = n_val[k]; m_addr[k] = n_addr[k]; m_src[k] = n_src[k];
      end
   endtask

   task automatic clear_inputs();
      in_valid = 0; ityp = TYPE_R; func = FUNC_ADD; imme = '0;
      rs_addr = '0; rt_addr = '0; rs_data = '0; rt_data = '0;
      fwd_valid = '0; fwd_rdy = '0; fwd_addr = '0; fwd_data = '0;
      flush = 0; out_ready = 0;
   endtask

   task automatic set_inst(input logic [W_TYPE-1:0] t, input logic [W_FUNC-1:0] f,
                           input logic [RADDR_W-1:0] rs, input logic [RADDR_W-1:0] rt,
                           input logic [DATA_W-1:0] rsd, input logic [DATA_W-1:0] rtd,
                           input logic [DATA_W-1:0] imm);
      ityp = t; func = f; rs_addr = rs; rt_addr = rt;
      rs_data = rsd; rt_data = rtd; imme = imm; in_valid = 1;
   endtask

   task automatic do_reset();
      clear_inputs();
      resetn = 0;
      model_clear();
      @(posedge clk);
      #1;
      resetn = 1;
   endtask

   task automatic test_reset();
      clear_inputs();
      resetn = 0;
      model_clear();
      #3;
      n_checks += 4;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      if (source_a !== '0) begin n_fail++; $display("FAIL reset_source_a got %h want 0", source_a); end
      if (source_b !== '0) begin n_fail++; $display("FAIL reset_source_b got %h want 0", source_b); end
      if (stall_cycles !== 16'd0) begin n_fail++; $display("FAIL reset_stall got %0d want 0", stall_cycles); end
      @(posedge clk);
      #1;
      resetn = 1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_basic();
      set_inst(TYPE_R, FUNC_ADD, 5'd3, 5'd4, 32'd10, 32'd20, 32'h0);
      out_ready = 0;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready got %b want 1", in_ready); end
      tick();
      in_valid = 0;
      n_checks += 3;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_out_valid got %b want 1", out_valid); end
      if (source_a !== 32'd10) begin n_fail++; $display("FAIL basic_a got %0d want 10", source_a); end
      if (source_b !== 32'd20) begin n_fail++; $display("FAIL basic_b got %0d want 20", source_b); end
      out_ready = 1;
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain got %b want 0", out_valid); end
   endtask

   task automatic test_fwd_priority();
      set_inst(TYPE_R, FUNC_SLL, 5'd2, 5'd5, 32'h11, 32'h22, 32'h0);
      fwd_valid = 3'b011; fwd_rdy = 3'b011;
      fwd_addr[0] = 5'd5; fwd_data[0] = 32'd7;
      fwd_addr[1] = 5'd5; fwd_data[1] = 32'd9;
      out_ready = 0;
      tick();
      in_valid = 0; fwd_valid = '0;
      n_checks += 3;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL prio_out_valid got %b want 1", out_valid); end
      if (source_a !== 32'd7) begin n_fail++; $display("FAIL prio_a got %0d want 7", source_a); end
      if (source_b !== 32'h11) begin n_fail++; $display("FAIL prio_b got %h want 11", source_b); end
      out_ready = 1;
      tick();
   endtask

   task automatic test_reg0();
      set_inst(TYPE_R, FUNC_ADD, 5'd0, 5'd1, 32'h0, 32'h33, 32'h0);
      fwd_valid = 3'b001; fwd_rdy = 3'b001;
      fwd_addr[0] = 5'd0; fwd_data[0] = 32'hFF;
      out_ready = 0;
      tick();
      in_valid = 0; fwd_valid = '0;
      n_checks += 2;
      if (source_a !== 32'h0) begin n_fail++; $display("FAIL reg0_a got %h want 0", source_a); end
      if (source_b !== 32'h33) begin n_fail++; $display("FAIL reg0_b got %h want 33", source_b); end
      out_ready = 1;
      tick();
   endtask

   task automatic test_wait();
      do_reset();
      set_inst(TYPE_I, FUNC_ADD, 5'd8, 5'd9, 32'h1, 32'h2, 32'h1234);
      fwd_valid = 3'b100; fwd_rdy = 3'b000;
      fwd_addr[2] = 5'd8; fwd_data[2] = 32'hDEAD;
      out_ready = 1;
      tick();
      in_valid = 0;
      for (int c = 0; c < 2; c++) begin
         #1;
         n_checks += 2;
         if (out_valid !== 1'b0) begin n_fail++; $display("FAIL wait_out_valid got %b want 0", out_valid); end
         if (in_ready !== 1'b0) begin n_fail++; $display("FAIL wait_in_ready got %b want 0", in_ready); end
         tick();
      end
      fwd_rdy = 3'b100; fwd_data[2] = 32'h55;
      tick();
      fwd_valid = '0; out_ready = 0;
      n_checks += 4;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL wait_done got %b want 1", out_valid); end
      if (source_a !== 32'h55) begin n_fail++; $display("FAIL wait_a got %h want 55", source_a); end
      if (source_b !== 32'h1234) begin n_fail++; $display("FAIL wait_b got %h want 1234", source_b); end
      if (stall_cycles !== 16'd3) begin n_fail++; $display("FAIL wait_stall got %0d want 3", stall_cycles); end
      out_ready = 1;
      tick();
   endtask

   task automatic test_back_to_back();
      set_inst(TYPE_R, FUNC_ADD, 5'd1, 5'd2, 32'h100, 32'h200, 32'h0);
      out_ready = 0;
      tick();
      set_inst(TYPE_R, FUNC_SUB, 5'd3, 5'd4, 32'h300, 32'h400, 32'h0);
      for (int c = 0; c < 4; c++) begin
         #1;
         n_checks++;
         if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_in_ready got %b want 0", in_ready); end
         tick();
         n_checks += 3;
         if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_hold_valid got %b want 1", out_valid); end
         if (source_a !== 32'h100) begin n_fail++; $display("FAIL b2b_hold_a got %h want 100", source_a); end
         if (source_b !== 32'h200) begin n_fail++; $display("FAIL b2b_hold_b got %h want 200", source_b); end
      end
      out_ready = 1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got %b want 1", in_ready); end
      tick();
      in_valid = 0;
      n_checks += 3;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_nobubble got %b want 1", out_valid); end
      if (source_a !== 32'h300) begin n_fail++; $display("FAIL b2b_a got %h want 300", source_a); end
      if (source_b !== 32'h400) begin n_fail++; $display("FAIL b2b_b got %h want 400", source_b); end
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b want 0", out_valid); end
   endtask

   task automatic test_flush_reset();
      logic [DATA_W-1:0] prev_a;
      prev_a = source_a;
      set_inst(TYPE_I, FUNC_SLT, 5'd8, 5'd9, 32'h1, 32'h2, 32'h7);
      fwd_valid = 3'b010; fwd_rdy = 3'b000; fwd_addr[1] = 5'd8;
      out_ready = 1;
      tick();
      flush = 1;
      set_inst(TYPE_R, FUNC_ADD, 5'd1, 5'd2, 32'hA, 32'hB, 32'h0);
      tick();
      flush = 0; in_valid = 0; fwd_valid = '0;
      #1;
      n_checks += 3;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b want 0", out_valid); end
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got %b want 1", in_ready); end
      if (source_a !== prev_a) begin n_fail++; $display("FAIL flush_src got %h want %h", source_a, prev_a); end
      set_inst(TYPE_R, FUNC_ADD, 5'd1, 5'd2, 32'hA, 32'hB, 32'h0);
      out_ready = 0;
      tick();
      in_valid = 0;
      n_checks++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL prereset_full got %b want 1", out_valid); end
      resetn = 0;
      model_clear();
      #1;
      n_checks += 3;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_full_valid got %b want 0", out_valid); end
      if (source_a !== '0) begin n_fail++; $display("FAIL rst_full_a got %h want 0", source_a); end
      if (source_b !== '0) begin n_fail++; $display("FAIL rst_full_b got %h want 0", source_b); end
      @(posedge clk);
      #1;
      resetn = 1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 3000; c++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         ityp      = W_TYPE'($urandom_range(0, 3));
         func      = W_FUNC'($urandom_range(0, 9));
         rs_addr   = RADDR_W'($urandom_range(0, 7));
         rt_addr   = RADDR_W'($urandom_range(0, 7));
         rs_data   = $urandom;
         rt_data   = $urandom;
         imme      = $urandom;
         fwd_valid = NFWD'($urandom);
         fwd_rdy   = NFWD'($urandom);
         for (int i = 0; i < NFWD; i++) begin
            fwd_addr[i] = RADDR_W'($urandom_range(0, 7));
            fwd_data[i] = $urandom;
         end
         flush     = ($urandom_range(0, 15) == 0);
         out_ready = $urandom_range(0, 1) != 0;
         #1;
         n_checks++;
         if (in_ready !== model_in_ready()) begin
            n_fail++; $display("FAIL rnd_in_ready cyc %0d got %b want %b", c, in_ready, model_in_ready());
         end
         tick();
         n_checks += 4;
         if (out_valid !== (m_st == 2)) begin
            n_fail++; $display("FAIL rnd_out_valid cyc %0d got %b want %b", c, out_valid, m_st == 2);
         end
         if (source_a !== m_src[0]) begin
            n_fail++; $display("FAIL rnd_a cyc %0d got %h want %h", c, source_a, m_src[0]);
         end
         if (source_b !== m_src[1]) begin
            n_fail++; $display("FAIL rnd_b cyc %0d got %h want %h", c, source_b, m_src[1]);
         end
         if (stall_cycles !== 16'(m_stall)) begin
            n_fail++; $display("FAIL rnd_stall cyc %0d got %0d want %0d", c, stall_cycles, m_stall);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_fwd_priority();
      test_reg0();
      test_wait();
      test_back_to_back();
      test_flush_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
